// File: rtl/hyper_trans_merge_if.sv
//----------------------------------------------------------------------------
// Module   : hyper_trans_merge_if
// Purpose  : start / sub-completion / merged-completion bundle for the merger
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface hyper_trans_merge_if #(
  parameter int TRANS_SIZE = 16,
  parameter int ID_WIDTH   = 1
);
  logic                  start_valid_i;
  logic                  start_ready_o;
  logic [TRANS_SIZE-1:0] start_size_i;
  logic [ID_WIDTH:0]     start_trans_id_i;
  logic                  start_rw_i;

  logic                  sub_done_i;
  logic [TRANS_SIZE-1:0] sub_size_i;
  logic                  sub_error_i;

  logic                  done_valid_o;
  logic                  done_ready_i;
  logic [ID_WIDTH:0]     done_trans_id_o;
  logic                  done_rw_o;
  logic [TRANS_SIZE-1:0] done_size_o;
  logic                  done_error_o;

  logic                  busy_o;
  logic                  overrun_o;

  // slave: the merger itself; master: whoever drives starts/pulses and consumes results
  modport slave (
    input  start_valid_i, start_size_i, start_trans_id_i, start_rw_i,
    input  sub_done_i, sub_size_i, sub_error_i, done_ready_i,
    output start_ready_o, done_valid_o, done_trans_id_o, done_rw_o,
    output done_size_o, done_error_o, busy_o, overrun_o
  );

  modport master (
    output start_valid_i, start_size_i, start_trans_id_i, start_rw_i,
    output sub_done_i, sub_size_i, sub_error_i, done_ready_i,
    input  start_ready_o, done_valid_o, done_trans_id_o, done_rw_o,
    input  done_size_o, done_error_o, busy_o, overrun_o
  );
endinterface

`default_nettype wire

// File: rtl/hyper_trans_merge.sv
//----------------------------------------------------------------------------
// Module   : hyper_trans_merge
// Purpose  : merges per-chunk HyperBus completions into one uDMA completion
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module hyper_trans_merge #(
  parameter int TRANS_SIZE     = 16,
  parameter int ID_WIDTH       = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  hyper_trans_merge_if.slave   bus
);

  localparam int                c_wd_w     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT_CYCLES);
  localparam logic [ID_WIDTH:0] c_no_trans = (ID_WIDTH + 1)'(1) << ID_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t                r_state;
  logic [TRANS_SIZE-1:0] r_rem;
  logic [TRANS_SIZE-1:0] r_acc;
  logic [ID_WIDTH:0]     r_id;
  logic                  r_rw;
  logic                  r_err;
  logic [c_wd_w-1:0]     r_wdog;

  logic [ID_WIDTH:0]     r_done_id;
  logic                  r_done_rw;
  logic [TRANS_SIZE-1:0] r_done_size;
  logic                  r_done_err;
  logic                  r_overrun;

  logic                  w_over;
  logic                  w_hit;
  logic [TRANS_SIZE-1:0] w_take;
  logic [c_wd_w-1:0]     w_wd_next;
  logic                  w_wd_expire;

  // Oversized chunks only contribute what was still outstanding, so acc saturates at the total
  assign w_over      = bus.sub_size_i > r_rem;
  assign w_hit       = bus.sub_size_i >= r_rem;
  assign w_take      = w_over ? r_rem : bus.sub_size_i;
  assign w_wd_next   = r_wdog + c_wd_w'(1);
  assign w_wd_expire = (TIMEOUT_CYCLES != 0) && (w_wd_next == c_wd_limit);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_acc       <= '0;
      r_id        <= c_no_trans;
      r_rw        <= 1'b0;
      r_err       <= 1'b0;
      r_wdog      <= '0;
      r_done_id   <= c_no_trans;
      r_done_rw   <= 1'b0;
      r_done_size <= '0;
      r_done_err  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Any pulse outside ACTIVE is stray; inside ACTIVE only an oversized one is
      r_overrun <= bus.sub_done_i && ((r_state != ST_ACTIVE) || w_over);

      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid_i) begin
            r_rem  <= bus.start_size_i;
            r_acc  <= '0;
            r_id   <= bus.start_trans_id_i;
            r_rw   <= bus.start_rw_i;
            r_err  <= 1'b0;
            r_wdog <= '0;
            if (bus.start_size_i == '0) begin
              r_state     <= ST_REPORT;
              r_done_id   <= bus.start_trans_id_i;
              r_done_rw   <= bus.start_rw_i;
              r_done_size <= '0;
              r_done_err  <= 1'b0;
            end else begin
              r_state <= ST_ACTIVE;
            end
          end
        end

        ST_ACTIVE: begin
          if (bus.sub_done_i) begin
            r_wdog <= '0;
            if (w_hit) begin
              r_state     <= ST_REPORT;
              r_rem       <= '0;
              r_acc       <= r_acc + w_take;
              r_err       <= r_err | bus.sub_error_i | w_over;
              r_done_id   <= r_id;
              r_done_rw   <= r_rw;
              r_done_size <= r_acc + w_take;
              r_done_err  <= r_err | bus.sub_error_i | w_over;
            end else begin
              r_rem <= r_rem - bus.sub_size_i;
              r_acc <= r_acc + bus.sub_size_i;
              r_err <= r_err | bus.sub_error_i;
            end
          end else if (w_wd_expire) begin
            r_state     <= ST_REPORT;
            r_err       <= 1'b1;
            r_done_id   <= r_id;
            r_done_rw   <= r_rw;
            r_done_size <= r_acc;
            r_done_err  <= 1'b1;
          end else begin
            r_wdog <= w_wd_next;
          end
        end

        ST_REPORT: begin
          if (bus.done_ready_i) begin
            r_state   <= ST_IDLE;
            r_done_id <= c_no_trans;
          end else if (bus.sub_done_i) begin
            r_done_err <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.start_ready_o   = (r_state == ST_IDLE);
  assign bus.busy_o          = (r_state != ST_IDLE);
  assign bus.done_valid_o    = (r_state == ST_REPORT);
  assign bus.done_trans_id_o = r_done_id;
  assign bus.done_rw_o       = r_done_rw;
  assign bus.done_size_o     = r_done_size;
  assign bus.done_error_o    = r_done_err;
  assign bus.overrun_o       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_hyper_trans_merge.sv
//----------------------------------------------------------------------------
// Module   : tb_hyper_trans_merge
// Purpose  : directed self-checking bench for hyper_trans_merge
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_hyper_trans_merge;

  localparam int TS  = 16;
  localparam int IDW = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hyper_trans_merge_if #(.TRANS_SIZE(TS), .ID_WIDTH(IDW)) bus ();

  hyper_trans_merge #(
    .TRANS_SIZE     (TS),
    .ID_WIDTH       (IDW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic start(input logic [TS-1:0] sz, input logic [IDW:0] id, input logic rw);
    bus.start_valid_i    = 1'b1;
    bus.start_size_i     = sz;
    bus.start_trans_id_i = id;
    bus.start_rw_i       = rw;
    cyc();
    bus.start_valid_i    = 1'b0;
  endtask

  task automatic pulse(input logic [TS-1:0] sz, input logic er);
    bus.sub_done_i  = 1'b1;
    bus.sub_size_i  = sz;
    bus.sub_error_i = er;
    cyc();
    bus.sub_done_i  = 1'b0;
    bus.sub_error_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    cyc();
    n_checks++; if (bus.start_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_start_ready: got %b expected 1", bus.start_ready_o); end
    n_checks++; if (bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_done_valid: got %b expected 0", bus.done_valid_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy_o); end
    n_checks++; if (bus.overrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", bus.overrun_o); end
    n_checks++; if ({bus.done_size_o, bus.done_error_o, bus.done_rw_o} !== 18'd0) begin n_fail++; $display("FAIL rst_done_fields: got size %0d err %b rw %b expected 0 0 0", bus.done_size_o, bus.done_error_o, bus.done_rw_o); end
    n_checks++; if (bus.done_trans_id_o !== 2'd2) begin n_fail++; $display("FAIL rst_done_id: got %0d expected 2", bus.done_trans_id_o); end
  endtask

  task automatic test_basic();
    start(16'd512, 2'd0, 1'b1);
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bus.busy_o); end
    pulse(16'd128, 1'b0);
    idle(2);
    pulse(16'd256, 1'b0);
    idle(2);
    n_checks++; if (bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", bus.done_valid_o); end
    pulse(16'd128, 1'b0);
    n_checks++; if (bus.done_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", bus.done_valid_o); end
    n_checks++; if (bus.done_size_o !== 16'd512) begin n_fail++; $display("FAIL basic_size: got %0d expected 512", bus.done_size_o); end
    n_checks++; if ({bus.done_error_o, bus.done_rw_o, bus.done_trans_id_o} !== 4'b0100) begin n_fail++; $display("FAIL basic_err_rw_id: got err %b rw %b id %0d expected 0 1 0", bus.done_error_o, bus.done_rw_o, bus.done_trans_id_o); end
    n_checks++; if (bus.overrun_o !== 1'b0) begin n_fail++; $display("FAIL basic_overrun: got %b expected 0", bus.overrun_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
    n_checks++; if (bus.done_valid_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin n_fail++; $display("FAIL basic_handshake: got valid %b ready %b expected 0 1", bus.done_valid_o, bus.start_ready_o); end
    n_checks++; if (bus.done_trans_id_o !== 2'd2) begin n_fail++; $display("FAIL basic_id_release: got %0d expected 2", bus.done_trans_id_o); end
  endtask

  task automatic test_overrun();
    start(16'd300, 2'd1, 1'b0);
    pulse(16'd200, 1'b0);
    n_checks++; if (bus.overrun_o !== 1'b0 || bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovr_first: got overrun %b valid %b expected 0 0", bus.overrun_o, bus.done_valid_o); end
    pulse(16'd200, 1'b0);
    n_checks++; if (bus.overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 1", bus.overrun_o); end
    n_checks++; if (bus.done_valid_o !== 1'b1 || bus.done_size_o !== 16'd300) begin n_fail++; $display("FAIL ovr_size: got valid %b size %0d expected 1 300", bus.done_valid_o, bus.done_size_o); end
    n_checks++; if ({bus.done_error_o, bus.done_rw_o, bus.done_trans_id_o} !== 4'b1001) begin n_fail++; $display("FAIL ovr_err_rw_id: got err %b rw %b id %0d expected 1 0 1", bus.done_error_o, bus.done_rw_o, bus.done_trans_id_o); end
    cyc();
    n_checks++; if (bus.overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle: got %b expected 0", bus.overrun_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
  endtask

  task automatic test_zero_size();
    start(16'd0, 2'd0, 1'b0);
    n_checks++; if (bus.done_valid_o !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %b expected 1", bus.done_valid_o); end
    n_checks++; if ({bus.done_size_o, bus.done_error_o, bus.done_rw_o} !== 18'd0) begin n_fail++; $display("FAIL zero_fields: got size %0d err %b rw %b expected 0 0 0", bus.done_size_o, bus.done_error_o, bus.done_rw_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    start(16'd256, 2'd1, 1'b1);
    pulse(16'd64, 1'b0);
    idle(15);
    // pulse lands exactly where the watchdog would have expired
    pulse(16'd64, 1'b0);
    n_checks++; if (bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL tmo_sub_wins: got %b expected 0", bus.done_valid_o); end
    idle(15);
    n_checks++; if (bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b expected 0", bus.done_valid_o); end
    cyc();
    n_checks++; if (bus.done_valid_o !== 1'b1) begin n_fail++; $display("FAIL tmo_expire: got %b expected 1", bus.done_valid_o); end
    n_checks++; if (bus.done_size_o !== 16'd128 || bus.done_error_o !== 1'b1) begin n_fail++; $display("FAIL tmo_fields: got size %0d err %b expected 128 1", bus.done_size_o, bus.done_error_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
  endtask

  task automatic test_hold();
    start(16'd64, 2'd0, 1'b1);
    pulse(16'd64, 1'b0);
    n_checks++; if (bus.done_valid_o !== 1'b1 || bus.done_error_o !== 1'b0) begin n_fail++; $display("FAIL hold_enter: got valid %b err %b expected 1 0", bus.done_valid_o, bus.done_error_o); end
    bus.start_valid_i    = 1'b1;
    bus.start_size_i     = 16'd32;
    bus.start_trans_id_i = 2'd1;
    bus.start_rw_i       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sub_done_i = (i == 2);
      bus.sub_size_i = 16'd8;
      cyc();
      bus.sub_done_i = 1'b0;
      n_checks++; if (bus.done_valid_o !== 1'b1 || bus.start_ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_valid_%0d: got valid %b ready %b expected 1 0", i, bus.done_valid_o, bus.start_ready_o); end
      n_checks++; if (bus.done_size_o !== 16'd64 || bus.done_trans_id_o !== 2'd0 || bus.done_rw_o !== 1'b1) begin n_fail++; $display("FAIL hold_stable_%0d: got size %0d id %0d rw %b expected 64 0 1", i, bus.done_size_o, bus.done_trans_id_o, bus.done_rw_o); end
      n_checks++; if (bus.overrun_o !== (i == 2)) begin n_fail++; $display("FAIL hold_overrun_%0d: got %b expected %b", i, bus.overrun_o, (i == 2)); end
    end
    n_checks++; if (bus.done_error_o !== 1'b1) begin n_fail++; $display("FAIL hold_stray_err: got %b expected 1", bus.done_error_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL hold_idle_gap: got busy %b expected 0", bus.busy_o); end
    cyc();
    bus.start_valid_i = 1'b0;
    n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL hold_next_start: got busy %b expected 1", bus.busy_o); end
    pulse(16'd32, 1'b0);
    n_checks++; if (bus.done_size_o !== 16'd32 || bus.done_trans_id_o !== 2'd1 || bus.done_error_o !== 1'b0) begin n_fail++; $display("FAIL hold_next_done: got size %0d id %0d err %b expected 32 1 0", bus.done_size_o, bus.done_trans_id_o, bus.done_error_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
  endtask

  task automatic test_start_with_sub();
    bus.sub_done_i = 1'b1;
    bus.sub_size_i = 16'd50;
    start(16'd50, 2'd1, 1'b0);
    bus.sub_done_i = 1'b0;
    n_checks++; if (bus.overrun_o !== 1'b1 || bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL sws_overrun: got overrun %b busy %b expected 1 1", bus.overrun_o, bus.busy_o); end
    n_checks++; if (bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL sws_ignored: got valid %b expected 0", bus.done_valid_o); end
    pulse(16'd50, 1'b0);
    n_checks++; if (bus.done_valid_o !== 1'b1 || bus.done_size_o !== 16'd50 || bus.done_error_o !== 1'b0) begin n_fail++; $display("FAIL sws_done: got valid %b size %0d err %b expected 1 50 0", bus.done_valid_o, bus.done_size_o, bus.done_error_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    start(16'd512, 2'd1, 1'b1);
    pulse(16'd128, 1'b0);
    rst = 1'b1;
    #2;
    n_checks++; if (bus.busy_o !== 1'b0 || bus.start_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_state: got busy %b ready %b expected 0 1", bus.busy_o, bus.start_ready_o); end
    n_checks++; if (bus.done_valid_o !== 1'b0 || bus.done_trans_id_o !== 2'd2) begin n_fail++; $display("FAIL rmid_outputs: got valid %b id %0d expected 0 2", bus.done_valid_o, bus.done_trans_id_o); end
    cyc();
    rst = 1'b0;
    cyc();
    start(16'd100, 2'd0, 1'b0);
    pulse(16'd60, 1'b1);
    n_checks++; if (bus.done_valid_o !== 1'b0) begin n_fail++; $display("FAIL rmid_fresh_partial: got valid %b expected 0", bus.done_valid_o); end
    pulse(16'd40, 1'b0);
    n_checks++; if (bus.done_valid_o !== 1'b1 || bus.done_size_o !== 16'd100) begin n_fail++; $display("FAIL rmid_fresh_size: got valid %b size %0d expected 1 100", bus.done_valid_o, bus.done_size_o); end
    n_checks++; if (bus.done_error_o !== 1'b1 || bus.overrun_o !== 1'b0) begin n_fail++; $display("FAIL rmid_fresh_err: got err %b overrun %b expected 1 0", bus.done_error_o, bus.overrun_o); end
    bus.done_ready_i = 1'b1;
    cyc();
    bus.done_ready_i = 1'b0;
  endtask

  initial begin
    n_checks             = 0;
    n_fail               = 0;
    rst                  = 1'b1;
    bus.start_valid_i    = 1'b0;
    bus.start_size_i     = '0;
    bus.start_trans_id_i = '0;
    bus.start_rw_i       = 1'b0;
    bus.sub_done_i       = 1'b0;
    bus.sub_size_i       = '0;
    bus.sub_error_i      = 1'b0;
    bus.done_ready_i     = 1'b0;

    test_reset();
    test_basic();
    test_overrun();
    test_zero_size();
    test_timeout();
    test_hold();
    test_start_with_sub();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hyper_trans_merge.md
# hyper_trans_merge

Completion-side counterpart of the transaction splitter in the uDMA HyperBus path. It registers one uDMA transaction (total byte count, transaction ID, direction) when the splitter accepts it. It then absorbs the per-sub-transaction completion pulses that the HyperBus controller returns for each page-bounded chunk. When the full byte count has been acknowledged, or a watchdog expires, it issues exactly one merged completion record towards the uDMA channel logic.

## Interface
Parameters:
- `TRANS_SIZE`, 16, width of byte counts.
- `ID_WIDTH`, 1, transaction-ID field is `ID_WIDTH+1` bits; value `1<<ID_WIDTH` means "no transaction".
- `TIMEOUT_CYCLES`, 1024, idle cycles allowed between sub-completions before abort; 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i`  in  1  block clock
- `rst_i`  in  1  asynchronous reset, active high
- `start_valid_i`  in  1  new transaction offered
- `start_ready_o`  out  1  block can accept a transaction
- `start_size_i`  in  TRANS_SIZE  total bytes of the transaction
- `start_trans_id_i`  in  ID_WIDTH+1  transaction ID
- `start_rw_i`  in  1  1 = read, 0 = write
- `sub_done_i`  in  1  one-cycle pulse: one sub-transaction finished
- `sub_size_i`  in  TRANS_SIZE  bytes covered by that sub-transaction
- `sub_error_i`  in  1  sub-transaction ended in error, qualified by `sub_done_i`
- `done_valid_o`  out  1  merged completion available
- `done_ready_i`  in  1  consumer takes the completion
- `done_trans_id_o`  out  ID_WIDTH+1  ID of the completed transaction
- `done_rw_o`  out  1  direction of the completed transaction
- `done_size_o`  out  TRANS_SIZE  bytes actually acknowledged
- `done_error_o`  out  1  any sub-error, overrun or timeout occurred
- `busy_o`  out  1  state is not IDLE
- `overrun_o`  out  1  one-cycle pulse: unexpected or oversized sub-completion

## Operation
- States:
  - IDLE: `start_ready_o`=1.
  - ACTIVE: collecting sub-completions.
  - REPORT: `done_valid_o`=1.
- IDLE, `start_valid_i & start_ready_o`:
  - Capture `rem <= start_size_i`, `acc <= 0`, ID, rw; clear `err`; clear watchdog.
  - Next state is ACTIVE. If `start_size_i==0`, next state is REPORT directly.
- ACTIVE, `sub_done_i`:
  - `err |= sub_error_i`; watchdog cleared.
  - `sub_size_i < rem`: `rem -= sub_size_i`, `acc += sub_size_i`, stay ACTIVE.
  - `sub_size_i == rem`: `acc += sub_size_i`, `rem <= 0`, go to REPORT.
  - `sub_size_i > rem`: `acc += rem` (saturating at the captured total), `err <= 1`, pulse `overrun_o`, go to REPORT.
  - `sub_size_i == 0`: no byte progress, but the watchdog is still cleared.
- ACTIVE, no `sub_done_i`:
  - Watchdog increments. When it reaches `TIMEOUT_CYCLES` (nonzero): `err <= 1`, go to REPORT with the partial `acc`.
- REPORT:
  - Hold `done_*` stable while `done_valid_o & !done_ready_i`.
  - On handshake: go to IDLE, and `done_trans_id_o` returns to `1<<ID_WIDTH`.
- `sub_done_i` in IDLE or REPORT: ignored for counting, pulses `overrun_o`. In REPORT it also sets `done_error_o` only if the record has not yet been handed over in that cycle.
- Arithmetic: `rem` and `acc` are TRANS_SIZE bits, unsigned; neither ever wraps.

## Timing
- Reset values:
  - State IDLE, `start_ready_o`=1, `done_valid_o`=0, `busy_o`=0, `overrun_o`=0.
  - `done_size_o`=0, `done_error_o`=0, `done_rw_o`=0, `done_trans_id_o`=`1<<ID_WIDTH`.
- Reset asserted mid-transaction aborts it immediately. No completion is emitted.
- `start_ready_o` and `busy_o` are decoded from the registered state.
- All `done_*` and `overrun_o` outputs are registered.
- `done_valid_o` rises the cycle after the completing `sub_done_i`, or the cycle after the start handshake when size is 0.
- A new start is accepted no earlier than the cycle after the done handshake (IDLE is occupied for at least 1 cycle).
- `sub_done_i` in the same cycle as the start handshake is treated as arriving in IDLE: ignored, `overrun_o` pulses.
- Watchdog expiry and `sub_done_i` in the same cycle: `sub_done_i` wins; the watchdog is cleared.

## Test plan
- Start size 512, id 0, read; sub-completions 128, 256, 128 spaced 3 cycles -> `done_valid_o` one cycle after the third; `done_size_o`=512, `done_error_o`=0, `done_rw_o`=1, id 0.
- Start size 300; sub 200 then 200 -> `overrun_o` pulses on the second; `done_size_o`=300, `done_error_o`=1.
- Start size 0, write -> `done_valid_o` on the cycle after the start handshake, `done_size_o`=0, no sub-completion needed.
- Start size 256, `TIMEOUT_CYCLES`=16; sub 128 then silence -> REPORT 16 cycles after the last pulse, `done_size_o`=128, `done_error_o`=1.
- REPORT with `done_ready_i` held low 5 cycles -> outputs stable; `start_ready_o`=0 throughout; `sub_done_i` during the hold pulses `overrun_o`.
- Assert `rst_i` mid-ACTIVE after 128 of 512 bytes -> outputs return to reset values; a new start is accepted afterwards with fresh counts.
